// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared widths, sequencer state encoding and default PC vectors.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int JIDX_W = 26;

  localparam logic [WORD_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/Shift_Left_Two.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Shift_Left_Two                                                       |
// | Word-offset to byte-offset conversion (logical shift left by two).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module Shift_Left_Two #(
  parameter int size = 32
) (
  input  logic [size-1:0] data_i,
  output logic [size-1:0] data_o
);

  assign data_o = data_i << 2;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer                                                         |
// | Registered next-PC controller with boot, stall, halt and jr trap.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [WORD_W-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  input  logic              jr_i,
  input  logic [WORD_W-1:0] imm_i,
  input  logic [JIDX_W-1:0] jidx_i,
  input  logic [WORD_W-1:0] rs_data_i,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] pc_plus4_o,
  output logic              fetch_valid_o,
  output logic              halted_o,
  output logic              trap_o
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc_nxt;
  logic              r_trap;
  logic              w_trap_nxt;

  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] w_br_off;
  logic [27:0]       w_jmp_field;
  logic [WORD_W-1:0] w_br_target;
  logic [WORD_W-1:0] w_jmp_target;
  logic              w_jr_misaligned;

  Shift_Left_Two #(.size(32)) u_br_shift (
    .data_i (imm_i),
    .data_o (w_br_off)
  );

  Shift_Left_Two #(.size(28)) u_jmp_shift (
    .data_i ({2'b00, jidx_i}),
    .data_o (w_jmp_field)
  );

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_br_target     = w_pc_plus4 + w_br_off;
  assign w_jmp_target    = {w_pc_plus4[31:28], w_jmp_field};
  assign w_jr_misaligned = (rs_data_i[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_trap  <= w_trap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_trap_nxt  = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (!stall_i) begin
          // Strict priority: halt > jr > jump > branch > sequential.
          if (halt_i) begin
            w_state_nxt = HALT;
          end else if (jr_i) begin
            if (w_jr_misaligned) begin
              w_pc_nxt   = TRAP_VECTOR;
              w_trap_nxt = 1'b1;
            end else begin
              w_pc_nxt = rs_data_i;
            end
          end else if (jump_i) begin
            w_pc_nxt = w_jmp_target;
          end else if (branch_taken_i) begin
            w_pc_nxt = w_br_target;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = BOOT;
    endcase
  end

  assign pc_o          = r_pc;
  assign pc_plus4_o    = w_pc_plus4;
  assign fetch_valid_o = (r_state == RUN);
  assign halted_o      = (r_state == HALT);
  assign trap_o        = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_sequencer                                                      |
// | Directed and randomized checks of pc_sequencer against a model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        jump_i = 1'b0;
  logic        jr_i = 1'b0;
  logic [31:0] imm_i = '0;
  logic [25:0] jidx_i = '0;
  logic [31:0] rs_data_i = '0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        halted_o;
  logic        trap_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: plain flags and arithmetic following the sequencing rules.
  logic        m_booting = 1'b1;
  logic        m_halted = 1'b0;
  logic        m_trap = 1'b0;
  logic [31:0] m_pc = 32'h0;

  pc_sequencer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .halt_i         (halt_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .jr_i           (jr_i),
    .imm_i          (imm_i),
    .jidx_i         (jidx_i),
    .rs_data_i      (rs_data_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .fetch_valid_o  (fetch_valid_o),
    .halted_o       (halted_o),
    .trap_o         (trap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_ctrl();
    rst_i = 1'b0; stall_i = 1'b0; halt_i = 1'b0; branch_taken_i = 1'b0;
    jump_i = 1'b0; jr_i = 1'b0; imm_i = '0; jidx_i = '0; rs_data_i = '0;
  endtask

  // Advance one clock, update the model from the inputs seen at that edge.
  task automatic tick();
    logic [31:0] p4;
    @(posedge clk_i);
    p4 = m_pc + 32'd4;
    if (rst_i) begin
      m_booting = 1'b1; m_halted = 1'b0; m_trap = 1'b0; m_pc = 32'h0;
    end else if (m_booting) begin
      m_booting = 1'b0; m_trap = 1'b0;
    end else if (m_halted || stall_i) begin
      m_trap = 1'b0;
    end else begin
      m_trap = 1'b0;
      if (halt_i)                  m_halted = 1'b1;
      else if (jr_i) begin
        if (rs_data_i % 4 != 0) begin m_pc = 32'h80; m_trap = 1'b1; end
        else m_pc = rs_data_i;
      end
      else if (jump_i)             m_pc = {p4[31:28], jidx_i, 2'b00};
      else if (branch_taken_i)     m_pc = p4 + imm_i * 4;
      else                         m_pc = p4;
    end
    #1;
  endtask

  task automatic load_pc(input logic [31:0] target);
    clear_ctrl(); jr_i = 1'b1; rs_data_i = target;
    tick();
    clear_ctrl();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    n_cmp++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
    n_cmp++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_fv got=%b exp=0", fetch_valid_o); end
    n_cmp++; if (halted_o !== 1'b0 || trap_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags halted=%b trap=%b exp=0/0", halted_o, trap_o); end
    clear_ctrl();
    #1;
    n_cmp++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL boot_fv got=%b exp=0", fetch_valid_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (pc_o !== exp_pc[i] || fetch_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL seq_%0d pc=%h fv=%b exp=%h/1", i, pc_o, fetch_valid_o, exp_pc[i]);
      end
    end
    n_cmp++; if (pc_plus4_o !== 32'h10) begin n_fail++; $display("FAIL seq_plus4 got=%h exp=%h", pc_plus4_o, 32'h10); end
  endtask

  task automatic test_branch();
    load_pc(32'h10);
    branch_taken_i = 1'b1; imm_i = 32'hFFFF_FFFD;
    tick();
    n_cmp++; if (pc_o !== 32'h08) begin n_fail++; $display("FAIL branch_back got=%h exp=%h", pc_o, 32'h08); end
    imm_i = 32'd3;
    tick();
    n_cmp++; if (pc_o !== 32'h18) begin n_fail++; $display("FAIL branch_fwd got=%h exp=%h", pc_o, 32'h18); end
    // Upper immediate bits fall off the shifted offset.
    imm_i = 32'hC000_0001;
    tick();
    n_cmp++; if (pc_o !== 32'h20) begin n_fail++; $display("FAIL branch_trunc got=%h exp=%h", pc_o, 32'h20); end
    clear_ctrl();
  endtask

  task automatic test_jump_priority();
    load_pc(32'h4000_0000);
    jump_i = 1'b1; jidx_i = 26'h0000040; branch_taken_i = 1'b1; imm_i = 32'd100;
    tick();
    n_cmp++; if (pc_o !== 32'h4000_0100) begin n_fail++; $display("FAIL jump got=%h exp=%h", pc_o, 32'h4000_0100); end
    jr_i = 1'b1; rs_data_i = 32'h200;
    tick();
    n_cmp++; if (pc_o !== 32'h200) begin n_fail++; $display("FAIL jr_over_jump got=%h exp=%h", pc_o, 32'h200); end
    clear_ctrl();
  endtask

  task automatic test_misaligned_jr();
    jr_i = 1'b1; rs_data_i = 32'h203;
    tick();
    clear_ctrl();
    n_cmp++; if (pc_o !== 32'h80 || trap_o !== 1'b1) begin n_fail++; $display("FAIL trap_entry pc=%h trap=%b exp=80/1", pc_o, trap_o); end
    tick();
    n_cmp++; if (pc_o !== 32'h84 || trap_o !== 1'b0) begin n_fail++; $display("FAIL trap_after pc=%h trap=%b exp=84/0", pc_o, trap_o); end
  endtask

  task automatic test_stall_wrap();
    load_pc(32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin
      stall_i = 1'b1; jr_i = 1'(i == 0); rs_data_i = 32'h3; jump_i = 1'(i == 1); halt_i = 1'(i == 2);
      tick();
      n_cmp++; if (pc_o !== 32'hFFFF_FFFC || trap_o !== 1'b0 || fetch_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_%0d pc=%h trap=%b fv=%b exp=fffffffc/0/1", i, pc_o, trap_o, fetch_valid_o);
      end
    end
    clear_ctrl();
    n_cmp++; if (pc_plus4_o !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4 got=%h exp=0", pc_plus4_o); end
    tick();
    n_cmp++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL wrap got=%h exp=0", pc_o); end
  endtask

  task automatic test_halt_reset();
    load_pc(32'h20);
    halt_i = 1'b1; jr_i = 1'b1; rs_data_i = 32'h44;
    tick();
    clear_ctrl(); jump_i = 1'b1; jidx_i = 26'h3FF;
    tick(); tick();
    n_cmp++; if (pc_o !== 32'h20 || halted_o !== 1'b1 || fetch_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL halt pc=%h halted=%b fv=%b exp=20/1/0", pc_o, halted_o, fetch_valid_o);
    end
    n_cmp++; if (pc_plus4_o !== 32'h24) begin n_fail++; $display("FAIL halt_plus4 got=%h exp=24", pc_plus4_o); end
    clear_ctrl(); rst_i = 1'b1;
    tick();
    n_cmp++; if (pc_o !== 32'h0 || halted_o !== 1'b0 || fetch_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL halt_reset pc=%h halted=%b fv=%b exp=0/0/0", pc_o, halted_o, fetch_valid_o);
    end
    clear_ctrl(); stall_i = 1'b1; jr_i = 1'b1; rs_data_i = 32'h100;
    tick();
    n_cmp++; if (pc_o !== 32'h0 || fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL boot_ignores_stall pc=%h fv=%b exp=0/1", pc_o, fetch_valid_o); end
    clear_ctrl();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_i          = ($urandom_range(0, 39) == 0);
      stall_i        = ($urandom_range(0, 3) == 0);
      halt_i         = ($urandom_range(0, 59) == 0);
      jr_i           = ($urandom_range(0, 5) == 0);
      jump_i         = ($urandom_range(0, 4) == 0);
      branch_taken_i = ($urandom_range(0, 2) == 0);
      imm_i          = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      jidx_i         = 26'($urandom);
      rs_data_i      = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick();
      n_cmp++; if (pc_o !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, pc_o, m_pc); end
      n_cmp++; if (pc_plus4_o !== m_pc + 32'd4) begin n_fail++; $display("FAIL rand_plus4 cyc=%0d got=%h exp=%h", i, pc_plus4_o, m_pc + 32'd4); end
      n_cmp++; if (fetch_valid_o !== (!m_booting && !m_halted)) begin n_fail++; $display("FAIL rand_fv cyc=%0d got=%b exp=%b", i, fetch_valid_o, !m_booting && !m_halted); end
      n_cmp++; if (halted_o !== m_halted) begin n_fail++; $display("FAIL rand_halted cyc=%0d got=%b exp=%b", i, halted_o, m_halted); end
      n_cmp++; if (trap_o !== m_trap) begin n_fail++; $display("FAIL rand_trap cyc=%0d got=%b exp=%b", i, trap_o, m_trap); end
    end
    clear_ctrl();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_misaligned_jr();
    test_stall_wrap();
    test_halt_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Registered next-PC controller for the single-cycle CPU with jump. Holds the program counter and selects the next fetch address among PC+4, branch target, jump target and register-indirect target. Adds boot, stall, halt and misaligned-target trap sequencing. Sits between the decoder/ALU control outputs and the instruction-memory address port, and owns both word-offset shift paths.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `TRAP_VECTOR`, default 32'h0000_0080: PC loaded on a misaligned `jr` target.
- `clk_i` input, 1: single clock; all state updates on its rising edge.
- `rst_i` input, 1: reset, synchronous and active-high.
- `stall_i` input, 1: hold PC and state this cycle.
- `halt_i` input, 1: decoded halt instruction; enter HALT.
- `branch_taken_i` input, 1: conditional branch resolved taken.
- `jump_i` input, 1: `j`/`jal` decoded.
- `jr_i` input, 1: `jr` decoded.
- `imm_i` input, 32: sign-extended branch immediate, word offset.
- `jidx_i` input, 26: jump instruction index field.
- `rs_data_i` input, 32: register value for `jr`.
- `pc_o` output, 32: current fetch address, registered.
- `pc_plus4_o` output, 32: `pc_o + 4`, combinational, feeds link register.
- `fetch_valid_o` output, 1: `pc_o` is a valid fetch address this cycle.
- `halted_o` output, 1: sequencer in HALT.
- `trap_o` output, 1: one-cycle pulse when a misaligned `jr` target is taken.

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset, any state: state=BOOT, `pc_o`=RESET_VECTOR, `fetch_valid_o`=0, `halted_o`=0, `trap_o`=0.
- BOOT: one bubble cycle; PC unchanged; next state is RUN, even if `stall_i` is high. All control inputs are ignored.
- RUN, `stall_i`=1: PC, state and outputs hold; `trap_o`=0; control inputs ignored.
- RUN, `stall_i`=0: next PC priority is `halt_i` > `jr_i` > `jump_i` > `branch_taken_i` > sequential.
  - `halt_i`: PC holds, next state HALT.
  - `jr_i`: if `rs_data_i[1:0]`≠0, load TRAP_VECTOR and pulse `trap_o` next cycle; else load `rs_data_i`.
  - `jump_i`: load `{pc_plus4[31:28], jidx_i, 2'b00}`.
  - `branch_taken_i`: load `pc_plus4 + (imm_i << 2)`; the shifted value is 32 bits and drops `imm_i[31:30]`.
  - Sequential: load `pc_plus4`.
- Arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 32'h0000_0000 is legal and unflagged.
- HALT: PC holds, `fetch_valid_o`=0, `halted_o`=1. Only `rst_i` exits HALT.
- Multiple control inputs asserted together resolve strictly by the priority above. This is not an error.

## Timing
- Next-PC selection is combinational from inputs and current PC; the update is registered, so latency is 1 cycle from control input to new `pc_o`.
- After `rst_i` deasserts: cycle 0 is BOOT (`fetch_valid_o`=0); cycle 1 is RUN with `pc_o`=RESET_VECTOR and `fetch_valid_o`=1.
- `fetch_valid_o`=1 exactly in RUN.
- `trap_o` is registered and is high for the single cycle in which `pc_o`=TRAP_VECTOR first appears.
- Reset asserted mid-stall, mid-trap or in HALT wins unconditionally on that edge.
- `pc_plus4_o` is valid in every state; it is not gated.

## Structure
- Shared package `cpu_pkg`: state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), `WORD_W=32`, `JIDX_W=26`, default vector constants.
- Reuse the existing `Shift_Left_Two` module twice:
  - `size=32` on `imm_i` for the branch offset.
  - `size=28` on `{2'b00, jidx_i}` for the jump field.
- No other sub-modules. The FSM and PC register live in one always block with a separate next-state combinational block.

## Test plan
- Reset then run free: deassert `rst_i`, no controls. `pc_o` shows 0, 0 (first cycle invalid), then 4, 8, 12; `fetch_valid_o` is 0 then 1.
- Branch: at PC=0x10, `branch_taken_i`=1, `imm_i`=32'hFFFF_FFFD. Next `pc_o`=0x08. Then `imm_i`=3 at PC=0x08 gives `pc_o`=0x18.
- Jump and priority:
  - At PC=0x4000_0000, `jump_i`=1, `jidx_i`=26'h0000040: next `pc_o`=0x4000_0100.
  - Same cycle with `jr_i`=1, `rs_data_i`=0x200: `pc_o`=0x200.
- Misaligned `jr`: `rs_data_i`=0x203. Next `pc_o`=0x80 and `trap_o`=1 for exactly 1 cycle; following cycle `pc_o`=0x84.
- Stall and wrap:
  - At PC=0xFFFF_FFFC, `stall_i`=1 for 3 cycles: `pc_o` holds.
  - Release: `pc_o`=0x0000_0000.
- Halt and reset: `halt_i`=1 at PC=0x20 gives `halted_o`=1, `fetch_valid_o`=0 and PC stays at 0x20 despite `jump_i`. A `rst_i` pulse returns to BOOT with `pc_o`=0.
